// File: rtl/adsb_tx.sv
// ADS-B / Mode S test-frame transmitter: SPI-loaded 56/112-bit buffer, emitted as
// a 16-chip preamble followed by PPM data at 8 clk8M cycles per bit.
module adsb_tx #(
    parameter int GAP_CYCLES = 16,
    parameter int MAX_BYTES  = 14
) (
    input  logic i_clk8M,
    input  logic i_rst,
    input  logic i_spi_sck,
    input  logic i_spi_mosi,
    input  logic i_spi_ss,
    output logic o_adsb_out,
    output logic o_busy,
    output logic o_tx_done,
    output logic o_err
);

    // state    | meaning
    // S_IDLE   | line low, SPI capture enabled
    // S_PRE    | 16 preamble chips, 4 cycles each
    // S_DATA   | PPM data bits, 8 cycles each
    // S_GAP    | enforced idle-low gap, busy still high
    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_PRE    = 2'd1;
    localparam logic [1:0]  S_DATA   = 2'd2;
    localparam logic [1:0]  S_GAP    = 2'd3;
    localparam logic [15:0] PREAMBLE = 16'b1010000101000000;
    localparam logic [4:0]  MAX_B    = 5'(MAX_BYTES);
    localparam logic [7:0]  GAP_LOAD = 8'(GAP_CYCLES - 1);

    logic       r_sck_s1, r_sck_s2, r_sck_d;
    logic       r_ss_s1, r_ss_s2, r_ss_d;
    logic       r_mosi_s1, r_mosi_s2;

    logic [6:0] r_shift;
    logic [2:0] r_bitcnt;
    logic [4:0] r_bytecnt;
    logic       r_ovf;
    logic       r_discard;
    logic [7:0] r_buf [16];

    logic [1:0] r_state;
    logic [2:0] r_phase;
    logic [3:0] r_chip;
    logic [6:0] r_bit;
    logic [6:0] r_last;
    logic [7:0] r_gap;
    logic       r_cur;

    logic       w_sck_rise, w_ss_rise, w_ss_fall, w_ss_low;
    logic       w_cap, w_wr_en, w_start_ok;
    logic [3:0] w_chip_nxt;
    logic [2:0] w_phase_nxt;
    logic [6:0] w_rd_idx;
    logic       w_rd_bit;

    assign w_sck_rise  = r_sck_s2 & ~r_sck_d;
    assign w_ss_rise   = r_ss_s2 & ~r_ss_d;
    assign w_ss_fall   = ~r_ss_s2 & r_ss_d;
    assign w_ss_low    = ~r_ss_s2;
    assign w_cap       = w_sck_rise & w_ss_low & ~w_ss_fall & (r_state == S_IDLE) & ~r_discard;
    assign w_wr_en     = w_cap & (r_bytecnt != MAX_B) & (r_bitcnt == 3'd7);
    assign w_start_ok  = (r_state == S_IDLE) && (r_bitcnt == 3'd0) && !r_ovf && !r_discard
                         && ((r_bytecnt == 5'd7) || (r_bytecnt == MAX_B));
    assign w_chip_nxt  = r_chip - 4'd1;
    assign w_phase_nxt = r_phase + 3'd1;
    // The preamble pre-fetches bit 0; data pre-fetches the bit after the current one.
    assign w_rd_idx    = (r_state == S_PRE) ? 7'd0 : r_bit + 7'd1;
    assign w_rd_bit    = r_buf[w_rd_idx[6:3]][~w_rd_idx[2:0]];

    always_ff @(posedge i_clk8M) begin
        if (i_rst) begin
            r_sck_s1  <= 1'b0;
            r_sck_s2  <= 1'b0;
            r_sck_d   <= 1'b0;
            r_ss_s1   <= 1'b1;
            r_ss_s2   <= 1'b1;
            r_ss_d    <= 1'b1;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_sck_s1  <= i_spi_sck;
            r_sck_s2  <= r_sck_s1;
            r_sck_d   <= r_sck_s2;
            r_ss_s1   <= i_spi_ss;
            r_ss_s2   <= r_ss_s1;
            r_ss_d    <= r_ss_s2;
            r_mosi_s1 <= i_spi_mosi;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    // A transfer that touches a busy period is poisoned until the next select.
    always_ff @(posedge i_clk8M) begin
        if (i_rst) begin
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_bytecnt <= '0;
            r_ovf     <= 1'b0;
            r_discard <= 1'b0;
        end else if (w_ss_fall) begin
            r_bitcnt  <= '0;
            r_bytecnt <= '0;
            r_ovf     <= 1'b0;
            r_discard <= (r_state != S_IDLE);
        end else if (w_sck_rise && w_ss_low) begin
            if (r_state != S_IDLE) begin
                r_discard <= 1'b1;
            end else if (!r_discard) begin
                if (r_bytecnt == MAX_B) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_shift  <= {r_shift[5:0], r_mosi_s2};
                    r_bitcnt <= r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7)
                        r_bytecnt <= r_bytecnt + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk8M) begin
        if (w_wr_en)
            r_buf[r_bytecnt[3:0]] <= {r_shift, r_mosi_s2};
    end

    always_ff @(posedge i_clk8M) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_phase    <= '0;
            r_chip     <= '0;
            r_bit      <= '0;
            r_last     <= '0;
            r_gap      <= '0;
            r_cur      <= 1'b0;
            o_adsb_out <= 1'b0;
            o_busy     <= 1'b0;
            o_tx_done  <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_tx_done <= 1'b0;
            o_err     <= w_ss_rise && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    o_adsb_out <= 1'b0;
                    o_busy     <= 1'b0;
                    if (w_ss_rise) begin
                        if (w_start_ok) begin
                            r_state    <= S_PRE;
                            r_phase    <= '0;
                            r_chip     <= 4'd15;
                            r_last     <= (r_bytecnt == 5'd7) ? 7'd55 : 7'd111;
                            o_adsb_out <= PREAMBLE[15];
                            o_busy     <= 1'b1;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                S_PRE: begin
                    r_phase <= w_phase_nxt;
                    if (r_phase[1:0] == 2'd3) begin
                        if (r_chip == 4'd0) begin
                            r_state    <= S_DATA;
                            r_bit      <= '0;
                            r_cur      <= w_rd_bit;
                            o_adsb_out <= w_rd_bit;
                        end else begin
                            r_chip     <= w_chip_nxt;
                            o_adsb_out <= PREAMBLE[w_chip_nxt];
                        end
                    end
                end
                S_DATA: begin
                    r_phase <= w_phase_nxt;
                    if (r_phase == 3'd7) begin
                        if (r_bit == r_last) begin
                            r_state    <= S_GAP;
                            r_gap      <= GAP_LOAD;
                            o_adsb_out <= 1'b0;
                        end else begin
                            r_bit      <= r_bit + 7'd1;
                            r_cur      <= w_rd_bit;
                            o_adsb_out <= w_rd_bit;
                        end
                    end else begin
                        o_adsb_out <= w_phase_nxt[2] ? ~r_cur : r_cur;
                    end
                end
                S_GAP: begin
                    o_adsb_out <= 1'b0;
                    if (r_gap == 8'd0) begin
                        r_state   <= S_IDLE;
                        o_busy    <= 1'b0;
                        o_tx_done <= 1'b1;
                    end else begin
                        r_gap <= r_gap - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adsb_tx.sv
// Scoreboarded bench for adsb_tx: SPI stimulus pushes expected frames and error
// pulses; independent monitors pop and compare against a waveform model.
module tb_adsb_tx;
    localparam int GAP = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0;
    logic mosi = 1'b0;
    logic ss = 1'b1;
    logic adsb_out, busy, tx_done, err;

    adsb_tx #(.GAP_CYCLES(GAP), .MAX_BYTES(14)) dut (
        .i_clk8M   (clk),
        .i_rst     (rst),
        .i_spi_sck (sck),
        .i_spi_mosi(mosi),
        .i_spi_ss  (ss),
        .o_adsb_out(adsb_out),
        .o_busy    (busy),
        .o_tx_done (tx_done),
        .o_err     (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           start;
        int           nb;
        int           abort;
        logic [111:0] d;
    } frame_t;

    frame_t     frame_q[$];
    int         err_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         exp_done = 0;
    int         n_done = 0;
    bit         mon_en = 1'b0;
    logic [7:0] tx [16];

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference waveform: preamble string, then each bit as a 4-high/4-low pair.
    function automatic logic exp_wave(input int nb, input logic [111:0] d, input int t);
        logic [15:0] pre;
        logic        b;
        pre = 16'b1010000101000000;
        if (t < 64) return pre[4'(15 - t / 4)];
        if (t < 64 + 8 * nb) begin
            b = d[7'(111 - (t - 64) / 8)];
            return (((t - 64) % 8) < 4) ? b : ~b;
        end
        return 1'b0;
    endfunction

    task automatic spi_send(input int nbits, input int half, output int e2);
        @(negedge clk);
        ss = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[4'(i / 8)][3'(7 - i % 8)];
            repeat (half) @(negedge clk);
            sck = 1'b1;
            repeat (half) @(negedge clk);
            sck = 1'b0;
        end
        repeat (half) @(negedge clk);
        ss = 1'b1;
        e2 = cyc + 3;
    endtask

    task automatic issue(input int nbits, input int half, input bit in_flight,
                         input int abort, output int e2, output bit legal);
        frame_t f;
        spi_send(nbits, half, e2);
        legal = !in_flight && (nbits == 56 || nbits == 112);
        if (legal) begin
            f.start = e2;
            f.nb    = nbits;
            f.abort = abort;
            f.d     = '0;
            for (int i = 0; i < nbits; i++) f.d[7'(111 - i)] = tx[4'(i / 8)][3'(7 - i % 8)];
            frame_q.push_back(f);
            if (abort == 0) exp_done++;
        end else begin
            err_q.push_back(e2);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic load_ref(input int nbytes);
        logic [7:0] ref_bytes [14];
        ref_bytes = '{8'h8D, 8'h48, 8'h40, 8'hD6, 8'h20, 8'h2C, 8'hC3,
                      8'h71, 8'hC3, 8'h2C, 8'hE0, 8'h57, 8'h60, 8'h98};
        for (int i = 0; i < nbytes; i++) tx[i] = ref_bytes[i];
    endtask

    task automatic load_rand(input int nbytes);
        for (int i = 0; i < nbytes; i++) tx[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin : frame_mon
        logic         bprev;
        frame_t       f;
        int           len, bad;
        logic [111:0] dec;
        bprev = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && busy && !bprev) begin
                if (frame_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_frame: busy rose at cycle %0d, expected no frame", cyc);
                end else begin
                    f = frame_q.pop_front();
                    chk("frame_start", cyc, f.start);
                    len = (f.abort > 0) ? f.abort : 64 + 8 * f.nb + GAP;
                    bad = 0;
                    dec = '0;
                    for (int t = 0; t < len; t++) begin
                        if (t > 0) @(negedge clk);
                        if (adsb_out !== exp_wave(f.nb, f.d, t) || busy !== 1'b1) bad++;
                        if (t >= 64 && t < 64 + 8 * f.nb && ((t - 64) % 8) == 2)
                            dec[7'(111 - (t - 64) / 8)] = adsb_out;
                    end
                    @(negedge clk);
                    chk("waveform_bad_cycles", bad, 0);
                    chk("busy_after_frame", busy, 0);
                    chk("adsb_after_frame", adsb_out, 0);
                    if (f.abort > 0) begin
                        chk("tx_done_after_reset", tx_done, 0);
                    end else begin
                        chk("tx_done_at_end", tx_done, 1);
                        n_vec++;
                        if (dec !== f.d) begin
                            n_err++;
                            $display("FAIL decoded_bits: got %h expected %h", dec, f.d);
                        end
                    end
                end
            end
            bprev = busy;
        end
    end

    always @(negedge clk) begin
        if (mon_en && err === 1'b1) begin
            if (err_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_err: err high at cycle %0d, expected low", cyc);
            end else begin
                chk("err_cycle", cyc, err_q.pop_front());
            end
        end
        if (mon_en && tx_done === 1'b1) n_done++;
        if (mon_en && busy !== 1'b1) chk("idle_line_low", adsb_out, 0);
    end

    initial begin : stim
        int e2;
        int e2b;
        bit legal;
        int nbits;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_adsb", adsb_out, 0);
        chk("reset_tx_done", tx_done, 0);
        chk("reset_err", err, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);

        // Reference 56- and 112-bit frames
        load_ref(7);
        issue(56, 4, 1'b0, 0, e2, legal);
        wait_until(e2 + 512 + GAP + 3);
        load_ref(14);
        issue(112, 4, 1'b0, 0, e2, legal);
        wait_until(e2 + 960 + GAP + 3);

        // Illegal lengths
        load_rand(16);
        issue(20, 3, 1'b0, 0, e2, legal);
        repeat (10) @(negedge clk);
        issue(64, 3, 1'b0, 0, e2, legal);
        repeat (10) @(negedge clk);
        issue(120, 3, 1'b0, 0, e2, legal);
        repeat (10) @(negedge clk);

        // Transfer attempted while a frame is in flight
        load_ref(7);
        issue(56, 3, 1'b0, 0, e2, legal);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 7; i++) tx[i] = 8'hFF;
        issue(56, 3, 1'b1, 0, e2b, legal);
        chk("second_xfer_inside_busy", (e2b < e2 + 512 + GAP) ? 1 : 0, 1);
        wait_until(e2 + 512 + GAP + 3);

        // sck activity with ss high must not be captured
        for (int i = 0; i < 10; i++) begin
            mosi = 1'($urandom_range(0, 1));
            sck = 1'b1;
            repeat (3) @(negedge clk);
            sck = 1'b0;
            repeat (3) @(negedge clk);
        end
        load_rand(7);
        issue(56, 4, 1'b0, 0, e2, legal);
        wait_until(e2 + 512 + GAP + 3);

        // Mid-frame reset at offset 300, then a normal frame
        load_rand(7);
        issue(56, 3, 1'b0, 301, e2, legal);
        wait_until(e2 + 300);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        load_rand(7);
        issue(56, 3, 1'b0, 0, e2, legal);
        wait_until(e2 + 512 + GAP + 3);

        // Randomized legal and illegal transfers
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0:       nbits = 56;
                1:       nbits = 112;
                2:       nbits = int'($urandom_range(1, 120));
                default: nbits = 8 * int'($urandom_range(1, 15));
            endcase
            load_rand(16);
            issue(nbits, int'($urandom_range(3, 6)), 1'b0, 0, e2, legal);
            if (legal) wait_until(e2 + 64 + 8 * nbits + GAP + 3);
            else repeat (10) @(negedge clk);
        end

        repeat (40) @(negedge clk);
        chk("frames_outstanding", frame_q.size(), 0);
        chk("errs_outstanding", err_q.size(), 0);
        chk("tx_done_count", n_done, exp_done);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
